// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared constants and types for the memory stage.
//   - FSM state encoding (IDLE, WAIT)
//   - access counter width, destination register width, data width
//   - MEM/WB pipeline register payload
package mem_stage_pkg;

   localparam int unsigned CNT_W  = 3;
   localparam int unsigned DEST_W = 4;
   localparam int unsigned DATA_W = 32;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   // MEM/WB payload (the address-fault flag lives outside so the default
   // build carries no unused field)
   typedef struct packed {
      logic              wb_en;
      logic              mem_r_en;
      logic [DEST_W-1:0] dest;
      logic [DATA_W-1:0] alu_res;
      logic [DATA_W-1:0] mem_data;
   } memwb_t;

endpackage

// File: rtl/mem_stage_data_memory.sv
// data_memory: DEPTH x 32 data array, synchronous write, asynchronous read.
// Ports:
//   clk      in   clock
//   we_i     in   write enable (commits on rising edge)
//   idx_i    in   word index
//   wdata_i  in   write data
//   rdata_o  out  combinational read of array[idx_i]
// Contents are intentionally not reset.
module data_memory
   import mem_stage_pkg::*;
#(
   parameter int unsigned DEPTH = 64,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     idx_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we_i) mem_q[idx_i] <= wdata_i;
   end

   // Asynchronous read port; returns the pre-write word on a write edge
   assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the pipelined core. Performs a data-memory
// read/write with WAIT_CYCLES wait states, stalls upstream while the access
// is in flight, and ends in the MEM/WB pipeline register.
// Optional macro MEM_STAGE_ADDR_CHECK_EN: adds address fault detection
// (misaligned or outside the array window) and the err_out port.
// Ports:
//   clk, rst (sync, active-high)
//   WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, dest_in, ALU_res_in, ST_value_in
//   stall          combinational freeze request to upstream
//   WB_EN_out, MEM_R_EN_out, dest_out, ALU_res_out, mem_data_out (registered)
//   err_out        registered address fault (macro builds only)
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned BASE_ADDR   = 1024,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              WB_EN_in,
   input  logic              MEM_R_EN_in,
   input  logic              MEM_W_EN_in,
   input  logic [DEST_W-1:0] dest_in,
   input  logic [DATA_W-1:0] ALU_res_in,
   input  logic [DATA_W-1:0] ST_value_in,
   output logic              stall,
   output logic              WB_EN_out,
   output logic              MEM_R_EN_out,
   output logic [DEST_W-1:0] dest_out,
   output logic [DATA_W-1:0] ALU_res_out,
   output logic [DATA_W-1:0] mem_data_out
`ifdef MEM_STAGE_ADDR_CHECK_EN
   ,
   output logic              err_out
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [DATA_W-1:0] BASE_W = DATA_W'(BASE_ADDR);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   memwb_t            memwb_q, memwb_d;
   logic              mem_op_c;
   logic              stall_raw_c;
   logic              fault_c;
   logic              we_c;
   logic [AW-1:0]     idx_c;
   logic [DATA_W-1:0] rdata_c;

   assign mem_op_c = MEM_R_EN_in | MEM_W_EN_in;

   // Word index: wraps modulo DEPTH
   assign idx_c = AW'((ALU_res_in - BASE_W) >> 2);

`ifdef MEM_STAGE_ADDR_CHECK_EN
   localparam logic [DATA_W-1:0] LIMIT_W = DATA_W'(BASE_ADDR + 4 * DEPTH);
   assign fault_c = (ALU_res_in[1:0] != 2'b00) ||
                    (ALU_res_in < BASE_W) || (ALU_res_in >= LIMIT_W);
`else
   assign fault_c = 1'b0;
`endif

   // Stall until the final cycle of a memory access; zero-wait builds never stall
   assign stall_raw_c = mem_op_c && (WAIT_CYCLES > 0) &&
                        !((state_q == ST_WAIT) && (cnt_q == '0));
   assign stall       = stall_raw_c & ~rst;

   // A write commits only on its completion edge and never under reset
   assign we_c = MEM_W_EN_in & ~stall_raw_c & ~fault_c & ~rst;

   data_memory #(.DEPTH(DEPTH)) u_dmem (
      .clk     (clk),
      .we_i    (we_c),
      .idx_i   (idx_c),
      .wdata_i (ST_value_in),
      .rdata_o (rdata_c)
   );

   // Wait-state FSM: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Wait-state FSM: next state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (mem_op_c && (WAIT_CYCLES > 0)) begin
               state_d = ST_WAIT;
               cnt_d   = CNT_W'(WAIT_CYCLES - 1);
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) state_d = ST_IDLE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // MEM/WB next value: bubble while stalled, else load the instruction
   always_comb begin
      memwb_d = memwb_q;
      if (stall_raw_c) begin
         memwb_d.wb_en    = 1'b0;
         memwb_d.mem_r_en = 1'b0;
      end else begin
         memwb_d.wb_en    = WB_EN_in;
         memwb_d.mem_r_en = MEM_R_EN_in;
         memwb_d.dest     = dest_in;
         memwb_d.alu_res  = ALU_res_in;
         memwb_d.mem_data = fault_c ? '0 : rdata_c;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) memwb_q <= '0;
      else     memwb_q <= memwb_d;
   end

`ifdef MEM_STAGE_ADDR_CHECK_EN
   logic err_q;

   // Fault flag travels with its instruction for one cycle only
   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= fault_c & ~stall_raw_c;
   end

   assign err_out = err_q;
`endif

   assign WB_EN_out    = memwb_q.wb_en;
   assign MEM_R_EN_out = memwb_q.mem_r_en;
   assign dest_out     = memwb_q.dest;
   assign ALU_res_out  = memwb_q.alu_res;
   assign mem_data_out = memwb_q.mem_data;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: three mem_stage instances (WAIT_CYCLES = 0, 2, 3) each run
// the same directed program from their own driver; a per-instance model of
// the stage (memory array + instruction latency) produces expected outputs,
// and one negedge process compares every instance every cycle.
module tb_mem_stage;

   typedef struct {
      bit          wb;
      bit          rd;
      bit          wr;
      logic [3:0]  dest;
      logic [31:0] alu;
      logic [31:0] st;
      int          rst_at;   // assert reset in this stall cycle (1-based), 0 = never
      bit          lit;
      logic [31:0] lit_val;
   } instr_t;

   logic clk;
   logic        rst_s [3];
   logic        wb_i  [3];
   logic        rd_i  [3];
   logic        wr_i  [3];
   logic [3:0]  dest_i[3];
   logic [31:0] alu_i [3];
   logic [31:0] st_i  [3];

   logic        stall_o[3];
   logic        wb_o   [3];
   logic        rd_o   [3];
   logic [3:0]  dest_o [3];
   logic [31:0] alu_o  [3];
   logic [31:0] data_o [3];
   logic        err_o  [3];

   // model expectations
   bit          chk_en [3];
   logic        e_stall[3];
   logic        e_wb   [3];
   logic        e_rd   [3];
   logic [3:0]  e_dest [3];
   logic [31:0] e_alu  [3];
   logic [31:0] e_data [3];
   bit          e_known[3];
   logic        e_err  [3];
   logic [31:0] mmem   [3][64];
   bit          mknown [3][64];

   int n_chk  = 0;
   int n_fail = 0;

`ifdef MEM_STAGE_ADDR_CHECK_EN
   localparam bit ADDR_CHECK = 1'b1;
`else
   localparam bit ADDR_CHECK = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   mem_stage #(.DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst_s[0]), .WB_EN_in(wb_i[0]), .MEM_R_EN_in(rd_i[0]),
      .MEM_W_EN_in(wr_i[0]), .dest_in(dest_i[0]), .ALU_res_in(alu_i[0]),
      .ST_value_in(st_i[0]), .stall(stall_o[0]), .WB_EN_out(wb_o[0]),
      .MEM_R_EN_out(rd_o[0]), .dest_out(dest_o[0]), .ALU_res_out(alu_o[0]),
      .mem_data_out(data_o[0])
`ifdef MEM_STAGE_ADDR_CHECK_EN
      , .err_out(err_o[0])
`endif
   );

   mem_stage #(.DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(2)) dut1 (
      .clk(clk), .rst(rst_s[1]), .WB_EN_in(wb_i[1]), .MEM_R_EN_in(rd_i[1]),
      .MEM_W_EN_in(wr_i[1]), .dest_in(dest_i[1]), .ALU_res_in(alu_i[1]),
      .ST_value_in(st_i[1]), .stall(stall_o[1]), .WB_EN_out(wb_o[1]),
      .MEM_R_EN_out(rd_o[1]), .dest_out(dest_o[1]), .ALU_res_out(alu_o[1]),
      .mem_data_out(data_o[1])
`ifdef MEM_STAGE_ADDR_CHECK_EN
      , .err_out(err_o[1])
`endif
   );

   mem_stage #(.DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(3)) dut2 (
      .clk(clk), .rst(rst_s[2]), .WB_EN_in(wb_i[2]), .MEM_R_EN_in(rd_i[2]),
      .MEM_W_EN_in(wr_i[2]), .dest_in(dest_i[2]), .ALU_res_in(alu_i[2]),
      .ST_value_in(st_i[2]), .stall(stall_o[2]), .WB_EN_out(wb_o[2]),
      .MEM_R_EN_out(rd_o[2]), .dest_out(dest_o[2]), .ALU_res_out(alu_o[2]),
      .mem_data_out(data_o[2])
`ifdef MEM_STAGE_ADDR_CHECK_EN
      , .err_out(err_o[2])
`endif
   );

   function automatic int wc_of(input int i);
      case (i)
         0:       return 0;
         1:       return 2;
         default: return 3;
      endcase
   endfunction

   function automatic instr_t mk(input bit wb, input bit rd, input bit wr,
                                 input logic [3:0] dest, input logic [31:0] alu,
                                 input logic [31:0] st, input int rst_at,
                                 input bit lit, input logic [31:0] lv);
      instr_t r;
      r.wb = wb; r.rd = rd; r.wr = wr; r.dest = dest; r.alu = alu; r.st = st;
      r.rst_at = rst_at; r.lit = lit; r.lit_val = lv;
      return r;
   endfunction

   task automatic check(input string nm, input int i,
                        input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d @%0t: got %h want %h", nm, i, $time, act, exp);
      end
   endtask

   task automatic set_inputs(input int i, input instr_t in);
      wb_i[i] = in.wb; rd_i[i] = in.rd; wr_i[i] = in.wr;
      dest_i[i] = in.dest; alu_i[i] = in.alu; st_i[i] = in.st;
   endtask

   task automatic model_reset(input int i);
      e_wb[i] = 1'b0; e_rd[i] = 1'b0; e_dest[i] = '0; e_alu[i] = '0;
      e_data[i] = '0; e_known[i] = 1'b1; e_err[i] = 1'b0;
   endtask

   // Completion of an instruction: what MEM/WB must hold afterwards
   task automatic model_complete(input int i, input instr_t in);
      int unsigned idx;
      bit fault;
      idx   = ((in.alu - 32'd1024) >> 2) % 64;
      fault = ADDR_CHECK && ((in.alu % 4) != 0 || in.alu < 32'd1024 || in.alu >= 32'd1280);
      e_wb[i] = in.wb; e_rd[i] = in.rd; e_dest[i] = in.dest; e_alu[i] = in.alu;
      e_err[i] = fault;
      if (fault) begin
         e_data[i] = '0; e_known[i] = 1'b1;
      end else begin
         e_data[i] = mmem[i][idx]; e_known[i] = mknown[i][idx];
         if (in.wr) begin
            mmem[i][idx] = in.st; mknown[i][idx] = 1'b1;
         end
      end
   endtask

   task automatic drive(input int i);
      int wc;
      instr_t prog[$];
      instr_t idle;
      wc   = wc_of(i);
      idle = mk(0, 0, 0, 4'd0, 32'd0, 32'd0, 0, 0, 32'd0);

      prog.push_back(mk(0, 0, 1, 4'd0, 32'd1024, 32'hDEADBEEF, 0, 0, 32'd0));
      prog.push_back(mk(1, 1, 0, 4'd5, 32'd1024, 32'd0, 0, 1, 32'hDEADBEEF));
      prog.push_back(mk(0, 0, 1, 4'd0, 32'd1028, 32'h12345678, 0, 0, 32'd0));
      prog.push_back(mk(1, 1, 0, 4'd7, 32'd1028, 32'd0, 0, 1, 32'h12345678));
      prog.push_back(mk(1, 1, 0, 4'd8, 32'd1028, 32'd0, 0, 1, 32'h12345678));
      prog.push_back(mk(1, 0, 0, 4'd3, 32'h55, 32'd0, 0, 0, 32'd0));
      prog.push_back(mk(0, 0, 1, 4'd0, 32'd1032, 32'h1, 0, 0, 32'd0));
      prog.push_back(mk(0, 0, 1, 4'd0, 32'd1032, 32'hAAAA5555, 2, 0, 32'd0));
      prog.push_back(mk(1, 1, 0, 4'd2, 32'd1032, 32'd0, 0, 1,
                        (wc >= 2) ? 32'h1 : 32'hAAAA5555));
      prog.push_back(mk(0, 0, 1, 4'd0, 32'd1280, 32'hCAFE, 0, 0, 32'd0));
      prog.push_back(mk(1, 1, 0, 4'd4, 32'd1024, 32'd0, 0, 1,
                        ADDR_CHECK ? 32'hDEADBEEF : 32'hCAFE));
      prog.push_back(mk(0, 0, 1, 4'd0, 32'd1036, 32'h7, 0, 0, 32'd0));
      prog.push_back(mk(1, 1, 1, 4'd6, 32'd1036, 32'h9, 0, 1, 32'h7));
      prog.push_back(mk(1, 1, 0, 4'd6, 32'd1036, 32'd0, 0, 1, 32'h9));
      prog.push_back(mk(1, 1, 0, 4'd9, 32'd1029, 32'd0, 0, 0, 32'd0));
      prog.push_back(mk(1, 1, 0, 4'd1, 32'd1000, 32'd0, 0, 0, 32'd0));
      prog.push_back(idle);

      // power-on reset: two cycles, then one idle cycle out of reset
      rst_s[i] = 1'b1; set_inputs(i, idle); e_stall[i] = 1'b0; chk_en[i] = 1'b0;
      @(posedge clk); #1;
      model_reset(i); chk_en[i] = 1'b1;
      @(posedge clk); #1;
      rst_s[i] = 1'b0;
      @(posedge clk); #1;
      model_complete(i, idle);

      foreach (prog[k]) begin
         instr_t in;
         bit memop, done, rnow;
         int age;
         in    = prog[k];
         memop = in.rd | in.wr;
         age   = 0;
         done  = 1'b0;
         set_inputs(i, in);
         while (!done) begin
            rnow = (in.rst_at > 0) && (wc >= in.rst_at) && (age == in.rst_at - 1);
            if (rnow) rst_s[i] = 1'b1;
            e_stall[i] = memop && (age < wc) && !rnow;
            @(posedge clk); #1;
            done = 1'b1;
            if (rnow) begin
               // aborted access: outputs cleared, then one idle cycle
               model_reset(i);
               rst_s[i] = 1'b0;
               set_inputs(i, idle);
               e_stall[i] = 1'b0;
               @(posedge clk); #1;
               model_complete(i, idle);
            end else if (memop && age < wc) begin
               e_wb[i] = 1'b0; e_rd[i] = 1'b0; e_err[i] = 1'b0;
               age++;
               done = 1'b0;
            end else begin
               model_complete(i, in);
               if (in.lit) check("model_lit", i, e_data[i], in.lit_val);
            end
         end
      end
      e_stall[i] = 1'b0;
      @(posedge clk); #1;
   endtask

   // Single compare process: every instance, every cycle, on the falling edge
   always @(negedge clk) begin
      for (int j = 0; j < 3; j++) begin
         if (chk_en[j]) begin
            check("stall",    j, 32'(stall_o[j]), 32'(e_stall[j]));
            check("WB_EN",    j, 32'(wb_o[j]),    32'(e_wb[j]));
            check("MEM_R_EN", j, 32'(rd_o[j]),    32'(e_rd[j]));
            check("dest",     j, 32'(dest_o[j]),  32'(e_dest[j]));
            check("ALU_res",  j, alu_o[j],        e_alu[j]);
            if (e_known[j]) check("mem_data", j, data_o[j], e_data[j]);
`ifdef MEM_STAGE_ADDR_CHECK_EN
            check("err", j, 32'(err_o[j]), 32'(e_err[j]));
`endif
         end
      end
   end

   initial begin
      for (int j = 0; j < 3; j++) begin
         chk_en[j] = 1'b0;
         for (int w = 0; w < 64; w++) mknown[j][w] = 1'b0;
      end
      fork
         drive(0);
         drive(1);
         drive(2);
      join
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      n_fail++;
      $display("FAIL watchdog: run did not complete, got timeout want finish");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
